param_rr_penc_arb: RTL
======================

// Module: param_rr_penc_arb
//
// PURPOSE
// - Registered round-robin priority encoder/arbiter over nreqs request lines,
//   with a val/rdy output handshake.
// - Successor to the combinational parametrised priority encoder. Adds a
//   rotating priority pointer, grant hold under backpressure and a
//   fixed/round-robin mode.
// - Sits in front of shared resources (ports, banks) to pick one requester per
//   transaction.
//
// PARAMETERS
// - nbits  8  number of request lines; legal range 2..64, not required to be a
//             power of two
// - rr_en  1  1 = round-robin priority, 0 = fixed priority (lowest index wins)
//
// PORTS
// - clk      in   1              clock, all state on posedge
// - reset_n  in   1              asynchronous, active-low reset
// - req      in   nbits          request vector, bit i = requester i
// - out_val  out  1              grant valid
// - out_rdy  in   1              consumer accepts the grant
// - out_idx  out  $clog2(nbits)  granted index, binary
// - out_oh   out  nbits          granted index, one-hot; all zero when !out_val
//
// BEHAVIOUR
// - Reset (async assert, sync deassert): out_val=0, out_idx=0, out_oh=0, ptr=0.
// - Handshake:
//   - fire = out_val & out_rdy.
//   - Registered grant may update when !out_val | out_rdy; otherwise it holds.
// - Grant hold: while out_val & !out_rdy, out_idx, out_oh and out_val stay
//   stable, even if req drops.
// - Pointer:
//   - ptr_next = fire ? wrap(out_idx+1) : ptr.
//   - wrap(nbits) = 0.
//   - ptr updates only when rr_en=1; with rr_en=0, ptr stays 0.
// - Selection (combinational, uses ptr_next):
//   - hi = req & mask(i >= ptr_next). If hi != 0, pick the lowest set bit of hi.
//   - Otherwise pick the lowest set bit of req.
//   - With rr_en=0, always pick the lowest set bit of req.
// - Update, when !out_val | out_rdy:
//   - out_val <= |req.
//   - out_idx <= pick, or 0 if req == 0.
//   - out_oh <= onehot(pick), or 0 if req == 0.
// - Latency: req sampled at edge t appears on the outputs after edge t.
//   One-cycle latency; the outputs are never combinational from req.
// - Back-to-back: a fire and a new pick happen in the same cycle, so the
//   throughput is one grant per cycle.
// - Fire-cycle selection: on a fire cycle, the granted requester is still
//   visible in req. It loses to any other requester at or above
//   ptr_next = idx+1, which gives fairness.
// - Single requester: with only one bit set, it is re-granted every cycle.
// - Wrap-around: grant at nbits-1 -> ptr=0. Non-power-of-two nbits never
//   produces idx >= nbits.
// - req=0 while out_val=0: stays idle, ptr unchanged.
// - Reset mid-operation: an asserted grant is dropped immediately and ptr
//   returns to 0. The first post-reset pick is the lowest index.
// - Invariants: out_oh == (out_val ? 1<<out_idx : 0); out_idx < nbits.
//
// STRUCTURE
// - Shared package: localparam idx_w = $clog2(nbits) function; no typedefs.
// - Sub-module param_penc_found:
//   - Combinational lowest-set-bit encoder: in_[nbits] -> out[idx_w], found.
//   - Instantiated twice, once on the masked vector and once on the unmasked
//     vector.
// - Top level: ptr register, mask generation, mux between the two encoders,
//   output registers.
// - Two always blocks: always_ff (async reset) and always_comb. No latches.
//
// TESTING (nbits=4 unless noted)
// - Reset: reset_n=0 with req=1111 -> out_val=0, out_oh=0000. After release,
//   first grant is idx 0.
// - RR rotation: req=1111, out_rdy=1 held -> grants 0,1,2,3,0,... one per
//   cycle.
// - Backpressure: req=0110, out_rdy=0 for 3 cycles -> idx 1 held stable.
//   Then set req=0000 with rdy=0 -> idx 1 still held. rdy=1 -> fire, then
//   out_val=0.
// - Fairness/wrap: grant idx 3 fires with req=1001 -> next grant is 0.
//   Then req=1001 -> next grant is 3.
// - Fixed mode (rr_en=0): req=1010, rdy=1 -> idx 1 every cycle.
//   req=1000 -> idx 3.
// - Non-power-of-two (nbits=5): req=10001 with rotation -> 0,4,0,4.
//   Random req/rdy for 10k cycles -> check invariants against a
//   cycle-accurate model.

Source files
------------

// File: rtl/param_rr_penc_arb_pkg.sv
// rtl/param_rr_penc_arb_pkg.sv - shared sizing helper for the round-robin priority encoder/arbiter
package param_rr_penc_arb_pkg;

  // Width of a binary index into n request lines.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_rr_penc_arb_penc_found.sv
// rtl/param_rr_penc_arb_penc_found.sv - combinational lowest-set-bit encoder with found flag
module param_penc_found
  import param_rr_penc_arb_pkg::*;
#(
  parameter int  nbits = 8,
  localparam int iw    = idx_w(nbits)
) (
  input  logic [nbits-1:0] in_,
  output logic [iw-1:0]    out,
  output logic             found
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    out   = '0;
    found = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (in_[i]) begin
        out   = iw'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_rr_penc_arb.sv
// rtl/param_rr_penc_arb.sv - registered round-robin priority arbiter with val/rdy grant handshake
module param_rr_penc_arb
  import param_rr_penc_arb_pkg::*;
#(
  parameter int  nbits = 8,
  parameter bit  rr_en = 1'b1,
  localparam int iw    = idx_w(nbits)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [nbits-1:0] req,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [iw-1:0]    out_idx,
  output logic [nbits-1:0] out_oh
);

  logic             val_q, val_d;
  logic [iw-1:0]    idx_q, idx_d;
  logic [iw-1:0]    ptr_q, ptr_d;
  logic [nbits-1:0] oh_q, oh_d;

  logic             fire, upd;
  logic [nbits-1:0] mask, hi;
  logic [iw-1:0]    hi_idx, lo_idx, pick;
  logic             hi_found, lo_found;

  assign fire = val_q & out_rdy;
  assign upd  = ~val_q | out_rdy;

  // Pointer moves one past the granted index on fire; explicit wrap keeps
  // non-power-of-two sizes inside 0..nbits-1.
  assign ptr_d = (rr_en && fire)
               ? ((idx_q == iw'(nbits - 1)) ? '0 : idx_q + 1'b1)
               : ptr_q;

  assign mask = ~((nbits'(1) << ptr_d) - nbits'(1));
  assign hi   = req & mask;

  param_penc_found #(.nbits(nbits)) u_penc_hi (
    .in_   (hi),
    .out   (hi_idx),
    .found (hi_found)
  );

  param_penc_found #(.nbits(nbits)) u_penc_lo (
    .in_   (req),
    .out   (lo_idx),
    .found (lo_found)
  );

  always_comb begin
    pick  = (rr_en && hi_found) ? hi_idx : lo_idx;
    val_d = val_q;
    idx_d = idx_q;
    oh_d  = oh_q;
    if (upd) begin
      val_d = lo_found;
      idx_d = lo_found ? pick : '0;
      oh_d  = lo_found ? (nbits'(1) << pick) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= 1'b0;
      idx_q <= '0;
      ptr_q <= '0;
      oh_q  <= '0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      oh_q  <= oh_d;
    end
  end

  assign out_val = val_q;
  assign out_idx = idx_q;
  assign out_oh  = oh_q;

endmodule
